gate_unit_pipe: RTL

- Parametrised, registered successor to the single-bit gate bank.
- Applies one of eight bitwise operations to WIDTH-bit operands A and B, selected per transaction by op.
- Operations are AND, OR, XOR, NOT, NAND, NOR, XNOR, plus an XOR accumulator.
- Results leave through a one-stage valid/ready output register, with zero and parity flags and a transaction counter.
- Sits between a producer (stimulus/switch logic) and a consumer (display/checker) that may stall.

---
 rtl/gate_unit_pipe.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/gate_unit_pipe.sv
// Registered WIDTH-bit gate unit: eight bitwise ops, XOR accumulator, valid/ready output with flags.
// Optional GATE_UNIT_SKID_EN adds a 2-entry skid buffer so in_ready no longer depends on out_ready.
module gate_unit_pipe #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Y,
   output logic             zero,
   output logic             parity,
   output logic [CNT_W-1:0] txn_count
);

   function automatic logic calc_parity(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction

   function automatic logic calc_zero(input logic [WIDTH-1:0] v);
      return (v == {WIDTH{1'b0}});
   endfunction

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] txn_q, txn_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             zero_q, zero_d;
   logic             parity_q, parity_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] res_s;
   logic [WIDTH-1:0] load_val_s;
   logic             load_s;
   logic             in_fire_s;

   assign in_fire_s = in_valid && in_ready;

   // Operation decode; XACC yields the post-update accumulator value
   always_comb begin
      res_s = {WIDTH{1'b0}};
      case (op)
         3'd0:    res_s = A & B;
         3'd1:    res_s = A | B;
         3'd2:    res_s = A ^ B;
         3'd3:    res_s = ~A;
         3'd4:    res_s = ~(A & B);
         3'd5:    res_s = ~(A | B);
         3'd6:    res_s = ~(A ^ B);
         3'd7:    res_s = acc_q ^ A;
         default: res_s = {WIDTH{1'b0}};
      endcase
   end

   // Accumulator and transaction counter advance in acceptance order
   always_comb begin
      acc_d = acc_q;
      txn_d = txn_q;
      if (in_fire_s) begin
         txn_d = txn_q + CNT_W'(1);
         if (op == 3'd7) begin
            acc_d = res_s;
         end else begin
            acc_d = acc_q;
         end
      end else begin
         txn_d = txn_q;
      end
   end

`ifdef GATE_UNIT_SKID_EN
   logic [WIDTH-1:0] skid0_q, skid0_d;
   logic [WIDTH-1:0] skid1_q, skid1_d;
   logic [1:0]       skid_cnt_q, skid_cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             out_free_s;
   logic             pop_s;
   logic             push_s;

   assign in_ready   = in_ready_q;
   assign out_free_s = !out_valid_q || out_ready;

   // Skid head feeds the output register ahead of any new result to keep order
   always_comb begin
      pop_s      = out_free_s && (skid_cnt_q != 2'd0);
      push_s     = in_fire_s && ((skid_cnt_q != 2'd0) || !out_free_s);
      load_s     = out_free_s && ((skid_cnt_q != 2'd0) || in_fire_s);
      load_val_s = (skid_cnt_q != 2'd0) ? skid0_q : res_s;
      skid0_d    = skid0_q;
      skid1_d    = skid1_q;
      skid_cnt_d = skid_cnt_q;
      if (pop_s) begin
         skid0_d = skid1_q;
         if (push_s && (skid_cnt_q == 2'd1)) begin
            skid0_d = res_s;
         end else if (push_s && (skid_cnt_q == 2'd2)) begin
            skid1_d = res_s;
         end else begin
            skid1_d = skid1_q;
         end
         skid_cnt_d = push_s ? skid_cnt_q : (skid_cnt_q - 2'd1);
      end else if (push_s) begin
         if (skid_cnt_q == 2'd0) begin
            skid0_d = res_s;
         end else begin
            skid1_d = res_s;
         end
         skid_cnt_d = skid_cnt_q + 2'd1;
      end else begin
         skid_cnt_d = skid_cnt_q;
      end
      in_ready_d = (skid_cnt_d != 2'd2);
   end

   // Skid storage and registered ready
   always_ff @(posedge clk) begin
      if (rst) begin
         skid0_q    <= {WIDTH{1'b0}};
         skid1_q    <= {WIDTH{1'b0}};
         skid_cnt_q <= 2'd0;
         in_ready_q <= 1'b1;
      end else begin
         skid0_q    <= skid0_d;
         skid1_q    <= skid1_d;
         skid_cnt_q <= skid_cnt_d;
         in_ready_q <= in_ready_d;
      end
   end
`else
   assign in_ready = !out_valid_q || out_ready;

   // Without a skid buffer the output register loads straight from the decode
   always_comb begin
      load_s     = in_fire_s;
      load_val_s = res_s;
   end
`endif

   // Output register: flags are derived from the value being loaded
   always_comb begin
      y_d         = y_q;
      zero_d      = zero_q;
      parity_d    = parity_q;
      out_valid_d = out_valid_q;
      if (load_s) begin
         y_d         = load_val_s;
         zero_d      = calc_zero(load_val_s);
         parity_d    = calc_parity(load_val_s);
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Datapath state; reset discards any pending output
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= {WIDTH{1'b0}};
         txn_q       <= {CNT_W{1'b0}};
         y_q         <= {WIDTH{1'b0}};
         zero_q      <= 1'b0;
         parity_q    <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         txn_q       <= txn_d;
         y_q         <= y_d;
         zero_q      <= zero_d;
         parity_q    <= parity_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign Y         = y_q;
   assign zero      = zero_q;
   assign parity    = parity_q;
   assign txn_count = txn_q;

endmodule
